swap_reg_bank: RTL
==================

Name: swap_reg_bank

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits wide.
- Executes WRITE, READ, SWAP and ROTATE commands under a valid/ready handshake.
- SWAP uses an explicit temp register in a three-step sequence (temp<=A, A<=B, B<=temp). ROTATE generalises this to a one-position left rotation of the whole bank.
- Sits as a small scratch-register/permutation unit beside datapath logic.

Parameters:
- WIDTH, 2, bits per register (>=1).
- DEPTH, 4, number of registers (>=2; need not be a power of 2).
- AW, $clog2(DEPTH) (min 1), index width. Local, derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 READ, 01 WRITE, 10 SWAP, 11 ROTATE.
- cmd_idx_a  in  AW  first index (READ/WRITE/SWAP).
- cmd_idx_b  in  AW  second index (READ/SWAP).
- cmd_wdata  in  WIDTH  WRITE data.
- rd_data_a  out  WIDTH  registered read of reg[idx_a].
- rd_data_b  out  WIDTH  registered read of reg[idx_b].
- temp_q  out  WIDTH  current temp register (debug).
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when an index is out of range.

Behaviour:
Reset (asynchronous, any time):
- reg[k] = k mod 2^WIDTH.
- temp_q, rd_data_a, rd_data_b, done, err = 0.
- FSM = IDLE; busy = 0.
- Any in-flight op is abandoned with no done pulse.
- cmd_ready = 0 while rst is high, and 1 in the first cycle after deassert.

Handshake:
- A command is accepted at edge E0 when cmd_valid && cmd_ready.
- Fields are latched at E0; inputs are don't-care afterwards.
- cmd_valid while busy is ignored and the command is not queued.

FSM states: IDLE, EXEC, LOAD, MOVE, STORE, ROT_SHIFT, ROT_STORE.
- Accepted READ or WRITE -> EXEC.
- Accepted SWAP -> LOAD.
- Accepted ROTATE -> LOAD with shift counter = 0.

READ:
- E1: rd_data_a/b <= reg[idx_a]/reg[idx_b]; done = 1; -> IDLE.

WRITE:
- E1: reg[idx_a] <= wdata; done = 1; -> IDLE.

SWAP:
- E1 (LOAD): temp <= reg[a].
- E2 (MOVE): reg[a] <= reg[b].
- E3 (STORE): reg[b] <= temp; done = 1; -> IDLE.
- a == b: full 3-cycle sequence, bank unchanged.

ROTATE (left by one, ignores indices):
- E1: temp <= reg[0].
- E2..E(DEPTH): reg[k] <= reg[k+1] for k = 0..DEPTH-2, one per edge.
- E(DEPTH+1): reg[DEPTH-1] <= temp; done = 1.

Timing and ordering:
- done and err are registered and high for exactly one cycle following the final update edge.
- New contents are visible in the same cycle as done.
- Next command can be accepted in that same cycle (cmd_ready = 1).

Out-of-range index (idx >= DEPTH, only possible for non-power-of-2 DEPTH):
- Applies to any used index (READ/SWAP: a or b; WRITE: a).
- Command is accepted and goes to EXEC.
- E1: no register or rd_data change; done = 1 and err = 1.

temp_q:
- Changes only in LOAD.
- Holds its value otherwise, including across IDLE.

Optional Feature:
Macro SWAP_REG_BANK_FAST_SWAP_EN.
- Defined: SWAP is a single-cycle parallel exchange at E1. reg[a] and reg[b] are both updated from their pre-edge values, done = 1 at E1, temp_q is not updated, and LOAD/MOVE/STORE are unused by SWAP. ROTATE is unchanged.
- Undefined: 3-cycle temp-based SWAP as specified above.

Test Plan:
1. WIDTH=2, DEPTH=4, reset then release -> reg = {0,1,2,3}; temp_q = 0; cmd_ready = 1 in the first cycle after release.
2. SWAP a=0, b=3 -> temp_q = 0 after E1; done at E3; READ(0,3) returns 3, 0; bank = {3,1,2,0}.
3. SWAP a=0, b=3 five times back-to-back -> bank alternates {3,1,2,0} / {0,1,2,3}, ending {3,1,2,0}; each done exactly 3 cycles after accept. With FAST_SWAP_EN: 1 cycle, temp_q stays 0.
4. ROTATE on {0,1,2,3} -> done at E5; bank = {1,2,3,0}; temp_q = 0; cmd_valid held during busy is not accepted.
5. SWAP a=1, b=2 then assert rst after E2 -> no done; bank returns to {0,1,2,3}; busy = 0.
6. DEPTH=5, WRITE a=6, wdata=2'b11 -> done = err = 1 at E1; bank unchanged {0,1,2,3,0}. Then WRITE a=4, wdata=3 -> err = 0; READ(4,4) returns 3.

Source files
------------

// File: rtl/swap_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : swap_reg_bank                                              |
// | Description : DEPTH x WIDTH register bank executing READ, WRITE, SWAP    |
// |               (temp-register exchange) and ROTATE (left by one) under a  |
// |               valid/ready handshake. Define SWAP_REG_BANK_FAST_SWAP_EN   |
// |               for a single-cycle parallel SWAP.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module swap_reg_bank #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_idx_a,
  input  logic [AW-1:0]    cmd_idx_b,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] temp_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] C_OP_READ   = 2'b00;
  localparam logic [1:0] C_OP_WRITE  = 2'b01;
  localparam logic [1:0] C_OP_SWAP   = 2'b10;
  localparam logic [1:0] C_OP_ROTATE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_LOAD      = 3'd2,
    S_MOVE      = 3'd3,
    S_STORE     = 3'd4,
    S_ROT_SHIFT = 3'd5,
    S_ROT_STORE = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [WIDTH-1:0] temp_d;
  logic [WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic             w_accept;

  // An index is legal only below DEPTH; one extra bit keeps the compare exact.
  function automatic logic idx_ok(input logic [AW-1:0] i);
    return ({1'b0, i} < (AW+1)'(DEPTH));
  endfunction

  // A command is "bad" when any index it actually uses is out of range.
  function automatic logic cmd_bad(input logic [1:0] op,
                                   input logic [AW-1:0] a,
                                   input logic [AW-1:0] b);
    case (op)
      C_OP_READ, C_OP_SWAP: return !idx_ok(a) || !idx_ok(b);
      C_OP_WRITE:           return !idx_ok(a);
      default:              return 1'b0;
    endcase
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

  // Next-state, bank update and completion flags for every FSM state.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    temp_d  = temp_q;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    op_d    = op_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          op_d    = cmd_op;
          idx_a_d = cmd_idx_a;
          idx_b_d = cmd_idx_b;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_op == C_OP_ROTATE) begin
            state_d = S_LOAD;
          end else if (cmd_op == C_OP_SWAP && !cmd_bad(cmd_op, cmd_idx_a, cmd_idx_b)) begin
`ifdef SWAP_REG_BANK_FAST_SWAP_EN
            state_d = S_EXEC;
`else
            state_d = S_LOAD;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (cmd_bad(op_q, idx_a_q, idx_b_q)) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            C_OP_READ: begin
              rd_a_d = bank_q[idx_a_q];
              rd_b_d = bank_q[idx_b_q];
            end
            C_OP_WRITE: bank_d[idx_a_q] = wdata_q;
`ifdef SWAP_REG_BANK_FAST_SWAP_EN
            C_OP_SWAP: begin
              bank_d[idx_a_q] = bank_q[idx_b_q];
              bank_d[idx_b_q] = bank_q[idx_a_q];
            end
`endif
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (op_q == C_OP_ROTATE) begin
          temp_d  = bank_q[0];
          cnt_d   = '0;
          state_d = S_ROT_SHIFT;
        end else begin
          temp_d  = bank_q[idx_a_q];
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        bank_d[idx_a_q] = bank_q[idx_b_q];
        state_d         = S_STORE;
      end
      S_STORE: begin
        bank_d[idx_b_q] = temp_q;
        done_d          = 1'b1;
        state_d         = S_IDLE;
      end
      S_ROT_SHIFT: begin
        bank_d[cnt_q] = bank_q[cnt_q + AW'(1)];
        if (cnt_q == AW'(DEPTH - 2)) begin
          state_d = S_ROT_STORE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_ROT_STORE: begin
        bank_d[DEPTH-1] = temp_q;
        done_d          = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched command fields, temp and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      temp_q  <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      op_q    <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      op_q    <= op_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_bank
      // Bank entry k resets to its own index so the permutation is observable.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bank_q[k] <= WIDTH'(k);
        end else begin
          bank_q[k] <= bank_d[k];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
